rename_retire_queue: RTL

- In-order retirement tracker that sits at the far end of the checkpointing rename register file.
- The rename stage enqueues every allocated physical name in program order, together with the checkpoint id when one was taken. Writeback marks entries done.
- The queue retires done entries from its head. Each retirement drives the rename file's free-name request (NAME_F/FE) and its checkpoint-release request (ROLLBK_E with DO_REL=1, DO_ROLL=0).
- On misprediction it truncates its tail so that squashed names are never freed twice; the rename file's rollback restores them instead.

---
 rtl/rename_retire_queue_pkg.sv | 43 ++++
 rtl/rename_retire_queue_if.sv | 36 +++
 rtl/rename_retire_queue_ptr_ctl.sv | 75 +++++++
 rtl/rename_retire_queue.sv | 119 +++++++++++
 4 files changed

// File: rtl/rename_retire_queue_pkg.sv
// Shared definitions for the rename retire queue.
//   NAME_W / REPLICA_W  : physical name and checkpoint id widths
//   RETQ_DEPTH          : number of queue slots (power of two, >= 2)
//   RETQ_IDX_W          : log2(RETQ_DEPTH)
//   retq_entry_t        : per-slot view {name, chk_valid, chk, done}
//   in_range()          : is a slot index inside the occupied window
//   keep_count()        : number of slots kept by a squash to idx
package rename_pkg;

  localparam int NAME_W     = 6;
  localparam int REPLICA_W  = 2;
  localparam int RETQ_DEPTH = 16;
  localparam int RETQ_IDX_W = 4;

  typedef logic [RETQ_IDX_W-1:0] idx_t;
  typedef logic [RETQ_IDX_W:0]   cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(RETQ_DEPTH);

  typedef struct packed {
    logic [NAME_W-1:0]    name;
    logic                 chk_valid;
    logic [REPLICA_W-1:0] chk;
    logic                 done;
  } retq_entry_t;

  // Distance from head wraps modulo depth because idx_t is exactly
  // RETQ_IDX_W bits wide; a slot is occupied when that distance < count.
  function automatic logic in_range(input idx_t idx, input idx_t head,
                                    input cnt_t count);
    idx_t offset;
    offset = idx - head;
    return ({1'b0, offset} < count);
  endfunction

  // Slots head..idx inclusive survive a squash.
  function automatic cnt_t keep_count(input idx_t idx, input idx_t head);
    idx_t offset;
    offset = idx - head;
    return {1'b0, offset} + cnt_t'(1);
  endfunction

endpackage

// File: rtl/rename_retire_queue_if.sv
// Handshake bundle between the rename/writeback side and the retire queue.
//   master : rename/writeback side (drives enqueue, done, squash)
//   slave  : retire queue (drives ready, tail index, free/release, status)
interface rename_retire_queue_if;
  import rename_pkg::*;

  logic                 enq_e;
  logic [NAME_W-1:0]    enq_name;
  logic                 enq_chk_valid;
  logic [REPLICA_W-1:0] enq_chk;
  logic                 enq_ready;
  idx_t                 enq_idx;
  logic                 done_e;
  idx_t                 done_idx;
  logic [NAME_W-1:0]    name_f;
  logic                 fe;
  logic                 rel_e;
  logic [REPLICA_W-1:0] rel_chk;
  logic                 squash_e;
  idx_t                 squash_idx;
  cnt_t                 count;
  logic                 empty;

  modport master (
    output enq_e, enq_name, enq_chk_valid, enq_chk,
    output done_e, done_idx, squash_e, squash_idx,
    input  enq_ready, enq_idx, name_f, fe, rel_e, rel_chk, count, empty
  );

  modport slave (
    input  enq_e, enq_name, enq_chk_valid, enq_chk,
    input  done_e, done_idx, squash_e, squash_idx,
    output enq_ready, enq_idx, name_f, fe, rel_e, rel_chk, count, empty
  );

endinterface

// File: rtl/rename_retire_queue_ptr_ctl.sv
// Head/tail/count bookkeeping for the retire queue.
//   clk, rst_n    : clock, asynchronous active-low reset
//   enq_fire      : an enqueue is accepted this cycle (never with squash)
//   retire        : the head entry retires this cycle
//   squash_e/idx  : squash request and youngest surviving slot
//   head/tail     : current pointers
//   count         : occupied entries
//   kept          : slots surviving a squash to squash_idx
//   squash_valid  : squash_idx lies inside the occupied window
module retq_ptr_ctl
  import rename_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enq_fire,
  input  logic retire,
  input  logic squash_e,
  input  idx_t squash_idx,
  output idx_t head,
  output idx_t tail,
  output cnt_t count,
  output cnt_t kept,
  output logic squash_valid
);

  idx_t head_reg, head_next;
  idx_t tail_reg, tail_next;
  cnt_t count_reg, count_next;

  assign squash_valid = squash_e && in_range(squash_idx, head_reg, count_reg);
  assign kept         = keep_count(squash_idx, head_reg);

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;

    if (retire) begin
      head_next = head_reg + idx_t'(1);
    end

    if (squash_valid) begin
      // A retiring head is always among the kept slots, so it comes off
      // the kept total rather than the old count.
      tail_next  = squash_idx + idx_t'(1);
      count_next = retire ? kept - cnt_t'(1) : kept;
    end else begin
      if (enq_fire) begin
        tail_next = tail_reg + idx_t'(1);
      end
      case ({enq_fire, retire})
        2'b10:   count_next = count_reg + cnt_t'(1);
        2'b01:   count_next = count_reg - cnt_t'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign head  = head_reg;
  assign tail  = tail_reg;
  assign count = count_reg;

endmodule

// File: rtl/rename_retire_queue.sv
// In-order retirement tracker for the checkpointing rename file.
// Entries are enqueued in program order, marked done by writeback and
// retired from the head, producing a free-name request (name_f/fe) and
// a checkpoint release (rel_e/rel_chk). A squash truncates the tail so
// squashed names are never freed here.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : rename_retire_queue_if.slave (enqueue, done, squash, retire)
module rename_retire_queue
  import rename_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  rename_retire_queue_if.slave bus
);

  logic [NAME_W-1:0]    name_mem [RETQ_DEPTH];
  logic [REPLICA_W-1:0] chk_mem  [RETQ_DEPTH];
  logic [RETQ_DEPTH-1:0] done_vec;
  logic [RETQ_DEPTH-1:0] chk_valid_vec;

  idx_t        head;
  idx_t        tail;
  cnt_t        count;
  cnt_t        kept;
  logic        squash_valid;
  logic        occupied;
  logic        enq_ready;
  logic        enq_fire;
  logic        retire;
  logic        done_occupied;
  retq_entry_t head_entry;

  retq_ptr_ctl u_ptr_ctl (
    .clk          (clk),
    .rst_n        (rst_n),
    .enq_fire     (enq_fire),
    .retire       (retire),
    .squash_e     (bus.squash_e),
    .squash_idx   (bus.squash_idx),
    .head         (head),
    .tail         (tail),
    .count        (count),
    .kept         (kept),
    .squash_valid (squash_valid)
  );

  // Ready is forced low in reset so nothing is accepted while the
  // rename file is also held in reset.
  assign occupied      = (count != '0);
  assign enq_ready     = rst_n && (count < DEPTH_CNT) && !bus.squash_e;
  assign enq_fire      = bus.enq_e && enq_ready;
  assign done_occupied = in_range(bus.done_idx, head, count);

  always_comb begin
    head_entry.name      = name_mem[head];
    head_entry.chk_valid = chk_valid_vec[head];
    head_entry.chk       = chk_mem[head];
    head_entry.done      = done_vec[head];
  end

  assign retire = occupied && head_entry.done;

  // Name/checkpoint payload needs no reset: it is only observed for
  // occupied slots, all of which were written on enqueue.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      name_mem[tail] <= bus.enq_name;
      chk_mem[tail]  <= bus.enq_chk;
    end
  end

  generate
    for (genvar gi = 0; gi < RETQ_DEPTH; gi++) begin : g_slot
      logic done_bit_reg;
      logic chk_valid_bit_reg;
      logic slot_retire;
      logic slot_discard;
      logic slot_enq;
      logic slot_done;

      assign slot_retire  = retire && (head == idx_t'(gi));
      assign slot_discard = squash_valid && !in_range(idx_t'(gi), head, kept);
      assign slot_enq     = enq_fire && (tail == idx_t'(gi));
      assign slot_done    = bus.done_e && done_occupied &&
                            (bus.done_idx == idx_t'(gi));

      // Clearing wins over a same-cycle done: a retiring or squashed
      // slot must not come back as done.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          done_bit_reg      <= 1'b0;
          chk_valid_bit_reg <= 1'b0;
        end else if (slot_retire || slot_discard) begin
          done_bit_reg      <= 1'b0;
          chk_valid_bit_reg <= 1'b0;
        end else if (slot_enq) begin
          done_bit_reg      <= 1'b0;
          chk_valid_bit_reg <= bus.enq_chk_valid;
        end else if (slot_done) begin
          done_bit_reg      <= 1'b1;
        end
      end

      assign done_vec[gi]      = done_bit_reg;
      assign chk_valid_vec[gi] = chk_valid_bit_reg;
    end
  endgenerate

  assign bus.enq_ready = enq_ready;
  assign bus.enq_idx   = tail;
  assign bus.fe        = retire;
  assign bus.name_f    = occupied ? head_entry.name : '0;
  assign bus.rel_e     = retire && head_entry.chk_valid;
  assign bus.rel_chk   = occupied ? head_entry.chk : '0;
  assign bus.count     = count;
  assign bus.empty     = !occupied;

endmodule
